// File: rtl/hd_pkg.sv
// Shared types and constants for the hd_receiver pipe-handshake receiver.
// Holds the FSM state encoding, counter widths and a saturating-increment helper.
package hd_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } hd_rx_state_t;

   localparam int HD_BEAT_CNT_W  = 32;
   localparam int HD_STALL_CNT_W = 16;

   // Holds at all-ones instead of wrapping
   function automatic logic [HD_STALL_CNT_W-1:0] hd_sat_inc(input logic [HD_STALL_CNT_W-1:0] v);
      return (v == '1) ? v : v + HD_STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/hd_receiver_if.sv
// Handshake bundle between sender, hd_receiver and downstream consumer.
// slave = receiver side, master = environment driving the receiver.
interface hd_receiver_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic                  ready_output;
   logic                  pipe_backup_valid;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ready_in;

   modport slave (
      input  pipe_valid,
      input  pipe_data,
      input  ready_in,
      output ready_output,
      output pipe_backup_valid,
      output valid_out,
      output data_out
   );

   modport master (
      output pipe_valid,
      output pipe_data,
      output ready_in,
      input  ready_output,
      input  pipe_backup_valid,
      input  valid_out,
      input  data_out
   );

endinterface

// File: rtl/hd_rx_stats.sv
// Beat and stall counters for hd_receiver (built only with HD_RECEIVER_STATS_EN).
// Beat count wraps, stall count saturates; a synchronous clear beats any increment.
module hd_rx_stats
   import hd_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      beat_inc,
   input  logic                      stall_inc,
   output logic [HD_BEAT_CNT_W-1:0]  beat_count,
   output logic [HD_STALL_CNT_W-1:0] stall_count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count  <= '0;
         stall_count <= '0;
      end else if (clr) begin
         beat_count  <= '0;
         stall_count <= '0;
      end else begin
         if (beat_inc) begin
            beat_count <= beat_count + HD_BEAT_CNT_W'(1);
         end
         if (stall_inc) begin
            stall_count <= hd_sat_inc(stall_count);
         end
      end
   end

endmodule

// File: rtl/hd_receiver.sv
// Receiving end of the valid/ready pipe: out register plus one-entry skid backup,
// registered ready to the sender. Optional counters under HD_RECEIVER_STATS_EN.
module hd_receiver
   import hd_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   hd_receiver_if.slave              bus
`ifdef HD_RECEIVER_STATS_EN
   ,
   input  logic                      stats_clr,
   output logic [HD_BEAT_CNT_W-1:0]  beat_count,
   output logic [HD_STALL_CNT_W-1:0] stall_count
`endif
);

   hd_rx_state_t          state_reg;
   hd_rx_state_t          state_next;
   logic                  valid_reg;
   logic                  backup_valid_reg;
   logic                  ready_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic [DATA_WIDTH-1:0] backup_data_reg;

   logic accept;
   logic pop;
   logic load_out;
   logic load_backup;

   assign accept = bus.pipe_valid & ready_reg;
   assign pop    = valid_reg & bus.ready_in;

   always_comb begin
      state_next  = state_reg;
      load_out    = 1'b0;
      load_backup = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = BUSY;
               load_out   = 1'b1;
            end
         end
         BUSY: begin
            if (accept && pop) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_next  = FULL;
               load_backup = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            // ready_reg is low here, so only a pop can happen
            if (pop) begin
               state_next = BUSY;
               load_out   = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= EMPTY;
         valid_reg        <= 1'b0;
         backup_valid_reg <= 1'b0;
         ready_reg        <= 1'b0;
         out_data_reg     <= '0;
         backup_data_reg  <= '0;
      end else begin
         state_reg        <= state_next;
         valid_reg        <= (state_next != EMPTY);
         backup_valid_reg <= (state_next == FULL);
         ready_reg        <= (state_next != FULL);
         if (load_out) begin
            out_data_reg <= (state_reg == FULL) ? backup_data_reg : bus.pipe_data;
         end
         if (load_backup) begin
            backup_data_reg <= bus.pipe_data;
         end
      end
   end

   assign bus.valid_out         = valid_reg;
   assign bus.pipe_backup_valid = backup_valid_reg;
   assign bus.ready_output      = ready_reg;
   assign bus.data_out          = out_data_reg;

`ifdef HD_RECEIVER_STATS_EN
   hd_rx_stats u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (stats_clr),
      .beat_inc    (accept),
      .stall_inc   (valid_reg & ~bus.ready_in),
      .beat_count  (beat_count),
      .stall_count (stall_count)
   );
`endif

endmodule
